// File: rtl/hidden_layer.sv
// rtl/hidden_layer.sv - two-layer fixed-point MAC datapath (10 -> 5 -> 3) with saturating neurons
// Weights are loaded row by row through inVal while WE is high; rows 0..N_HID-1 are hidden, the rest output.
module hidden_layer #(
    parameter int WIDTH = 10,
    parameter int N_IN  = 10,
    parameter int N_HID = 5,
    parameter int N_OUT = 3,
    parameter int SHIFT = 0
) (
    input  logic                          Clock,
    input  logic                          Rst,
    input  logic                          WE,
    input  logic                          In,
    input  logic [N_IN-1:0][WIDTH-1:0]    inVal,
    output logic [N_HID-1:0][WIDTH-1:0]   outVal,
    output logic [N_OUT-1:0][WIDTH-1:0]   outVal1
);

    localparam int ACC_W  = 2*WIDTH + 4;
    localparam int N_ROWS = N_HID + N_OUT;
    localparam int PTR_W  = $clog2(N_ROWS);
    localparam logic [ACC_W-1:0] MAX_ACC = {{(ACC_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(N_ROWS - 1);

    logic [WIDTH-1:0] xReg [N_IN];
    logic [WIDTH-1:0] wh   [N_HID][N_IN];
    logic [WIDTH-1:0] wo   [N_OUT][N_HID];
    logic [PTR_W-1:0] ptr;

    logic [ACC_W-1:0] hidAcc [N_HID];
    logic [ACC_W-1:0] outAcc [N_OUT];

    function automatic logic [WIDTH-1:0] sat(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> SHIFT;
        if (s > MAX_ACC)
            return {WIDTH{1'b1}};
        else
            return s[WIDTH-1:0];
    endfunction

    // Both layers read registered operands only, so outputs never see inputs combinationally.
    always_comb begin
        for (int j = 0; j < N_HID; j++) begin
            hidAcc[j] = '0;
            for (int i = 0; i < N_IN; i++)
                hidAcc[j] = hidAcc[j] + ACC_W'(wh[j][i]) * ACC_W'(xReg[i]);
        end
        for (int k = 0; k < N_OUT; k++) begin
            outAcc[k] = '0;
            for (int j = 0; j < N_HID; j++)
                outAcc[k] = outAcc[k] + ACC_W'(wo[k][j]) * ACC_W'(outVal[j]);
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            ptr <= '0;
            for (int i = 0; i < N_IN; i++)
                xReg[i] <= '0;
            for (int j = 0; j < N_HID; j++) begin
                outVal[j] <= '0;
                for (int i = 0; i < N_IN; i++)
                    wh[j][i] <= WIDTH'(1);
            end
            for (int k = 0; k < N_OUT; k++) begin
                outVal1[k] <= '0;
                for (int j = 0; j < N_HID; j++)
                    wo[k][j] <= WIDTH'(1);
            end
        end else if (WE) begin
            // Weight load freezes the pipeline regardless of In.
            for (int j = 0; j < N_HID; j++)
                if (ptr == PTR_W'(j))
                    for (int i = 0; i < N_IN; i++)
                        wh[j][i] <= inVal[i];
            for (int k = 0; k < N_OUT; k++)
                if (ptr == PTR_W'(N_HID + k))
                    for (int j = 0; j < N_HID; j++)
                        wo[k][j] <= inVal[j];
            ptr <= (ptr == LAST_ROW) ? '0 : ptr + PTR_W'(1);
        end else if (In) begin
            for (int i = 0; i < N_IN; i++)
                xReg[i] <= inVal[i];
            for (int j = 0; j < N_HID; j++)
                outVal[j] <= sat(hidAcc[j]);
            for (int k = 0; k < N_OUT; k++)
                outVal1[k] <= sat(outAcc[k]);
        end
    end

endmodule

// File: tb/tb_hidden_layer.sv
// tb/tb_hidden_layer.sv - directed-vector bench for hidden_layer
module tb_hidden_layer;

    logic                 Clock = 1'b0;
    logic                 Rst;
    logic                 WE;
    logic                 In;
    logic [9:0][9:0]      inVal;
    logic [4:0][9:0]      outVal;
    logic [2:0][9:0]      outVal1;

    int nVec = 0;
    int nBad = 0;

    hidden_layer dut (
        .Clock   (Clock),
        .Rst     (Rst),
        .WE      (WE),
        .In      (In),
        .inVal   (inVal),
        .outVal  (outVal),
        .outVal1 (outVal1)
    );

    always #5 Clock = ~Clock;

    task automatic setAll(input logic [9:0] v);
        for (int i = 0; i < 10; i++)
            inVal[i] = v;
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic pulseReset();
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; WE = 1'b0; In = 1'b1; setAll(10'd7);
        step(2);
        for (int j = 0; j < 5; j++) begin
            nVec++;
            if (outVal[j] !== 10'd0) begin
                nBad++;
                $display("FAIL reset outVal[%0d]: got %0d expected 0", j, outVal[j]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            nVec++;
            if (outVal1[k] !== 10'd0) begin
                nBad++;
                $display("FAIL reset outVal1[%0d]: got %0d expected 0", k, outVal1[k]);
            end
        end
        Rst = 1'b1;
    endtask

    task automatic test_default(input string tag);
        WE = 1'b0; In = 1'b1; setAll(10'd1);
        step(3);
        for (int j = 0; j < 5; j++) begin
            nVec++;
            if (outVal[j] !== 10'd10) begin
                nBad++;
                $display("FAIL %s outVal[%0d]: got %0d expected 10", tag, j, outVal[j]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            nVec++;
            if (outVal1[k] !== 10'd50) begin
                nBad++;
                $display("FAIL %s outVal1[%0d]: got %0d expected 50", tag, k, outVal1[k]);
            end
        end
    endtask

    task automatic test_hold();
        In = 1'b0; setAll(10'd5);
        for (int c = 0; c < 3; c++) begin
            step(2);
            nVec++;
            if (outVal !== {5{10'd10}}) begin
                nBad++;
                $display("FAIL hold outVal: got %h expected all 10", outVal);
            end
            nVec++;
            if (outVal1 !== {3{10'd50}}) begin
                nBad++;
                $display("FAIL hold outVal1: got %h expected all 50", outVal1);
            end
        end
    endtask

    task automatic test_weight_load();
        pulseReset();
        WE = 1'b1; In = 1'b1; setAll(10'd3);
        step(1);
        nVec++;
        if (outVal !== '0) begin
            nBad++;
            $display("FAIL we_priority outVal: got %h expected 0", outVal);
        end
        WE = 1'b0; setAll(10'd1);
        step(3);
        for (int j = 0; j < 5; j++) begin
            nVec++;
            if (outVal[j] !== ((j == 0) ? 10'd30 : 10'd10)) begin
                nBad++;
                $display("FAIL wload outVal[%0d]: got %0d expected %0d", j, outVal[j], (j == 0) ? 30 : 10);
            end
        end
        for (int k = 0; k < 3; k++) begin
            nVec++;
            if (outVal1[k] !== 10'd70) begin
                nBad++;
                $display("FAIL wload outVal1[%0d]: got %0d expected 70", k, outVal1[k]);
            end
        end
    endtask

    task automatic test_saturation();
        pulseReset();
        WE = 1'b0; In = 1'b1; setAll(10'd1023);
        step(3);
        nVec++;
        if (outVal !== {5{10'd1023}}) begin
            nBad++;
            $display("FAIL sat outVal: got %h expected all 1023", outVal);
        end
        nVec++;
        if (outVal1 !== {3{10'd1023}}) begin
            nBad++;
            $display("FAIL sat outVal1: got %h expected all 1023", outVal1);
        end
    endtask

    task automatic test_ptr_wrap();
        pulseReset();
        WE = 1'b1; In = 1'b0; setAll(10'd2);
        step(8);
        setAll(10'd1);
        step(1);
        WE = 1'b0; In = 1'b1;
        step(3);
        for (int j = 0; j < 5; j++) begin
            nVec++;
            if (outVal[j] !== ((j == 0) ? 10'd10 : 10'd20)) begin
                nBad++;
                $display("FAIL wrap outVal[%0d]: got %0d expected %0d", j, outVal[j], (j == 0) ? 10 : 20);
            end
        end
        for (int k = 0; k < 3; k++) begin
            nVec++;
            if (outVal1[k] !== 10'd180) begin
                nBad++;
                $display("FAIL wrap outVal1[%0d]: got %0d expected 180", k, outVal1[k]);
            end
        end
        // Asynchronous reset mid-run, checked between clock edges.
        #2;
        Rst = 1'b0;
        #1;
        nVec++;
        if (outVal !== '0 || outVal1 !== '0) begin
            nBad++;
            $display("FAIL midreset outputs: got %h / %h expected 0", outVal, outVal1);
        end
        Rst = 1'b1;
        test_default("after_reset");
    endtask

    initial begin
        test_reset();
        test_default("default");
        test_hold();
        test_weight_load();
        test_saturation();
        test_ptr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
